io_sw_debounce: RTL

Input-conditioning stage directly upstream of the pipelined core's switch input. It takes raw, asynchronous DE-board slide-switch/key levels and synchronises them into clk_i. It debounces each bit independently and drives the clean level vector that feeds the core's io_sw_i port. It also emits per-bit one-cycle rise/fall pulses and a summary change flag for future interrupt/status use.

---
 rtl/io_sw_debounce.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/io_sw_debounce.sv
// -----------------------------------------------------------------------------
// io_sw_debounce
//
// Input conditioning for the board slide switches and keys that feed the core's
// io_sw_i port. Each raw level is brought into clk_i through a two-flop
// synchroniser, then debounced independently per bit. The bit's stable level
// only changes after DEBOUNCE_CYCLES consecutive clock cycles in which the
// synchronised level disagrees with it. Registered one-cycle rise and fall
// pulses, plus a summary change flag, come out alongside the clean levels.
//
// Parameters
//   WIDTH            number of switch bits conditioned
//   DEBOUNCE_CYCLES  consecutive mismatching cycles before a bit flips
//                    (legal range 1 .. 2**CNT_W-1)
//   CNT_W            width of each per-bit debounce counter
//
// Ports
//   clk_i         system clock, shared with the core
//   rst_ni        asynchronous active-low reset; the release is expected to
//                 be synchronised to clk_i upstream
//   sw_raw_i      raw switch/key levels, asynchronous to clk_i
//   bypass_i      1 = skip debouncing, sw_o follows the synchroniser output
//   sw_o          debounced stable levels
//   sw_rise_o     one-cycle pulse per bit when that sw_o bit goes 0->1
//   sw_fall_o     one-cycle pulse per bit when that sw_o bit goes 1->0
//   sw_changed_o  high in exactly the cycles where any rise/fall bit is high
//
// Every output is driven directly by a flop; there is no combinational path
// from any input to any output.
// -----------------------------------------------------------------------------
module io_sw_debounce #(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] sw_raw_i,
    input  logic             bypass_i,
    output logic [WIDTH-1:0] sw_o,
    output logic [WIDTH-1:0] sw_rise_o,
    output logic [WIDTH-1:0] sw_fall_o,
    output logic             sw_changed_o
);

    // Terminal count: on the cycle a mismatching bit's counter already holds
    // this value, the mismatch has lasted DEBOUNCE_CYCLES cycles and the bit
    // flips. With DEBOUNCE_CYCLES = 1 this is zero, so the first mismatching
    // cycle flips the bit and the counter never moves.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] s1_q;              // first synchroniser stage
    logic [WIDTH-1:0] s2_q;              // second stage, sole debounce source
    logic [CNT_W-1:0] cnt_q [WIDTH];     // per-bit mismatch run length

    // -------------------------------------------------------------------------
    // Next-state values
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] sw_d;
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;
    logic             changed_d;

    // -------------------------------------------------------------------------
    // Debounce decision, one independent slice per bit.
    //
    // bypass_i is a quasi-static test/simulation control and is used without
    // synchronisation. While it is high the counters are forced to zero, so a
    // count in progress is abandoned and normal operation resumes from zero
    // once it drops, with sw_o starting from whatever level it last held.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here receives a default before any
        // conditional update, so no path leaves it unassigned and no latch is
        // inferred.
        sw_d = sw_o;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (bypass_i) begin
                sw_d[i] = s2_q[i];
            end else if (s2_q[i] != sw_o[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    sw_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
            // A matching bit leaves cnt_d at zero: any bounce back to the
            // stable level restarts the run from the beginning.
        end
    end

    // Edge detection looks at the level about to be registered, so the pulse
    // flops and sw_o update on the same edge and the pulse is visible in the
    // very cycle sw_o shows its new value. A bit cannot be both 0->1 and 1->0
    // in one cycle, so rise and fall are mutually exclusive per bit.
    always_comb begin
        rise_d    = sw_d & ~sw_o;
        fall_d    = ~sw_d & sw_o;
        changed_d = |(sw_d ^ sw_o);
    end

    // -------------------------------------------------------------------------
    // Synchroniser: two plain flops per bit, nothing between the stages.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // s2_q samples the old s1_q on this edge; a blocking assignment would
        // collapse the two stages into one.
        if (!rst_ni) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= sw_raw_i;
            s2_q <= s1_q;
        end
    end

    // -------------------------------------------------------------------------
    // Counters, stable levels and pulse outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the counter bank is a set of individual flops rather than
            // a RAM, so it can and must be cleared by reset; a count left
            // over from before reset would shorten the first debounce after it.
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            sw_o         <= '0;
            sw_rise_o    <= '0;
            sw_fall_o    <= '0;
            sw_changed_o <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            sw_o         <= sw_d;
            sw_rise_o    <= rise_d;
            sw_fall_o    <= fall_d;
            sw_changed_o <= changed_d;
        end
    end

endmodule
